load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Data-memory access stage directly downstream of the multicycle control FSM's MEMADR/MEMREAD/MEMWRITE path. It takes one load/store request (address from ALU result, funct3, rs2 data), generates byte enables and lane-shifted write data, and runs a valid/ready handshake to data memory. It sign- or zero-extends load data and returns one completion pulse so the FSM can leave MEMREAD/MEMWRITE. Misaligned accesses, illegal funct3 values and bus timeouts are flagged, never issued.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed in REQ+WAIT_R before abort with error; 0 disables timeout
(Address and data widths are fixed at 32.)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request from control FSM
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data (rs2)
req_ready  out  1  high only in IDLE and not in reset
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data
resp_err  out  1  valid with resp_valid: misaligned, illegal funct3 or timeout
busy  out  1  state != IDLE
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accept
mem_we  out  1  bus write
mem_be  out  4  byte enables
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word

Behaviour:
- Reset (async): state IDLE, timeout counter 0, all outputs 0 (req_ready low while reset high). Request registers cleared. An in-flight bus transaction is abandoned; any later mem_rvalid is ignored.
- States: IDLE, REQ, WAIT_R, DONE (lsu_state_t).
- IDLE: if req_valid, capture all request fields.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal funct3 (load 3/6/7, store >=3) -> DONE with err=1. No bus request is issued.
  - Otherwise -> REQ.
- REQ: mem_req_valid=1. mem_we, mem_be, mem_addr and mem_wdata are driven from registers and held stable until mem_req_ready.
  - On handshake, store -> DONE; load -> WAIT_R.
- WAIT_R: on mem_rvalid, register the extended data -> DONE. mem_rvalid in any other state is ignored.
- DONE: resp_valid=1 for exactly one cycle with resp_err -> IDLE. A request cannot be accepted in DONE.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/WAIT_R. At TIMEOUT_CYCLES it forces DONE with err=1 and drops mem_req_valid.
- Byte enables:
  - SB/LB/LBU: 1<<addr[1:0].
  - SH/LH/LHU: addr[1] ? 1100 : 0011.
  - SW/LW: 1111.
- Write data:
  - SB: byte replicated to all 4 lanes.
  - SH: halfword replicated to both halves.
  - SW: as-is.
- Load extension:
  - LB: sign-extend the lane selected by addr[1:0].
  - LBU: zero-extend the lane selected by addr[1:0].
  - LH/LHU: half selected by addr[1], sign- or zero-extended.
  - LW: passthrough.
- resp_rdata holds until the next completion. It is 0 for stores and errors.
- Latency with req_valid at cycle N and ready/rvalid immediate:
  - Store: resp_valid at N+2.
  - Load with rvalid at N+2: resp_valid at N+3.
  - Error: resp_valid at N+1.

Decomposition:
- Shared package types.svh gains:
  - lsu_state_t.
  - funct3 constants F3_LB/LH/LW/LBU/LHU, F3_SB/SH/SW.
  - mem_size_t.
- One combinational sub-module, lsu_align: (funct3, addr[1:0], wdata, rdata) -> (be, wdata_shifted, rdata_ext, misaligned, illegal). It is reused for both directions and unit-tested alone.

Test Plan:
- SB addr 0x1003, wdata 0x000000A5, ready=1 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, resp_valid at N+2, err=0.
- LB addr 0x2001, mem_rdata 0x0000_8000 -> resp_rdata=0xFFFFFF80; LBU same address -> 0x00000080.
- LH addr 0x2002, mem_rdata 0x8001_0000 -> resp_rdata=0xFFFF8001; mem_req_ready held low 5 cycles -> outputs stable throughout, resp at handshake+1 (store) or rvalid+1 (load).
- LW addr 0x3002 -> no mem_req_valid, resp_valid at N+1, err=1; funct3=3'b011 load -> err=1.
- Load with mem_rvalid never asserted, TIMEOUT_CYCLES=8 -> resp_valid with err=1 after 8 cycles in REQ+WAIT_R; a late rvalid has no effect.
- Assert reset in WAIT_R -> all outputs 0 immediately, IDLE after deassert, stray mem_rvalid ignored, next SW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RV32I load/store funct3 codes and access-size decoding.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // The low two funct3 bits encode access size for both loads and stores.
  function automatic mem_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// extension and legality checks. Shared by the request and response paths.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_shifted,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  mem_size_t   size_s;
  logic [31:0] lane_s;
  logic [15:0] half_s;
  logic        sext_s;

  assign size_s = f3_size(funct3);
  assign lane_s = rdata >> {addr_lo, 3'b000};
  assign half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign sext_s = ~funct3[2];

  // Legality: funct3 codes outside the RV32I set, and natural-alignment rule.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      illegal = (funct3 > F3_SW);
    end else begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    case (size_s)
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Lane steering for both directions.
  always_comb begin
    be            = 4'b0000;
    wdata_shifted = 32'd0;
    rdata_ext     = 32'd0;
    case (size_s)
      SZ_BYTE: begin
        be            = 4'b0001 << addr_lo;
        wdata_shifted = {4{wdata[7:0]}};
        rdata_ext     = {{24{sext_s & lane_s[7]}}, lane_s[7:0]};
      end
      SZ_HALF: begin
        be            = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_shifted = {2{wdata[15:0]}};
        rdata_ext     = {{16{sext_s & half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        be            = 4'b1111;
        wdata_shifted = wdata;
        rdata_ext     = rdata;
      end
      default: begin
        be            = 4'b0000;
        wdata_shifted = 32'd0;
        rdata_ext     = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: accepts one load/store, runs the valid/ready bus
// handshake, extends load data and returns a single completion pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

  lsu_state_t  state_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] cnt_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        al_store_s;
  logic [2:0]  al_funct3_s;
  logic [1:0]  al_addr_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_sh_s;
  logic [31:0] rdata_ext_s;
  logic        misaligned_s;
  logic        illegal_s;
  logic        timeout_s;

  // In IDLE the aligner sees the incoming request; afterwards the captured one.
  assign al_store_s  = (state_q == ST_IDLE) ? req_write       : write_q;
  assign al_funct3_s = (state_q == ST_IDLE) ? req_funct3      : funct3_q;
  assign al_addr_s   = (state_q == ST_IDLE) ? req_addr[1:0]   : addr_lo_q;
  assign timeout_s   = TO_EN && (cnt_q == TO_LAST);

  lsu_align u_align (
    .is_store      (al_store_s),
    .funct3        (al_funct3_s),
    .addr_lo       (al_addr_s),
    .wdata         (req_wdata),
    .rdata         (mem_rdata),
    .be            (be_s),
    .wdata_shifted (wdata_sh_s),
    .rdata_ext     (rdata_ext_s),
    .misaligned    (misaligned_s),
    .illegal       (illegal_s)
  );

  // Request FSM with registered bus and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      cnt_q        <= 32'd0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= 32'd0;
          if (req_valid) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            if (misaligned_s || illegal_s) begin
              state_q      <= ST_DONE;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q     <= ST_REQ;
              mem_we_q    <= req_write;
              mem_be_q    <= be_s;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wdata_q <= req_write ? wdata_sh_s : 32'd0;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 32'd1;
          if (mem_req_ready || timeout_s) begin
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
          end
          if (mem_req_ready) begin
            if (write_q) begin
              state_q      <= ST_DONE;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q <= ST_WAIT_R;
            end
          end else if (timeout_s) begin
            state_q      <= ST_DONE;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end
        end
        ST_WAIT_R: begin
          cnt_q <= cnt_q + 32'd1;
          if (mem_rvalid) begin
            state_q      <= ST_DONE;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= rdata_ext_s;
          end else if (timeout_s) begin
            state_q      <= ST_DONE;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          resp_err_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && !reset;
  assign busy          = (state_q != ST_IDLE);
  assign resp_valid    = (state_q == ST_DONE);
  assign mem_req_valid = (state_q == ST_REQ);
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
